// File: rtl/cl_video_pkg.sv
// Shared video definitions for the Camera Link to raster bridge.
// Holds default 720p timing, FSM state encoding, FIFO payload layout,
// the pixel width and the colour-bar palette used by the fallback pattern.
package cl_video_pkg;

   localparam int unsigned PIX_W = 24;

   // Default 1280x720 raster timing
   localparam int unsigned DEF_H_ACTIVE = 1280;
   localparam int unsigned DEF_H_FP     = 110;
   localparam int unsigned DEF_H_SYNC   = 40;
   localparam int unsigned DEF_H_BP     = 220;
   localparam int unsigned DEF_V_ACTIVE = 720;
   localparam int unsigned DEF_V_FP     = 5;
   localparam int unsigned DEF_V_SYNC   = 5;
   localparam int unsigned DEF_V_BP     = 20;
   localparam int unsigned DEF_FIFO_AW  = 11;

   // Output FSM encoding
   localparam logic [1:0] ST_SEEK       = 2'd0;
   localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
   localparam logic [1:0] ST_RUN        = 2'd2;

   // FIFO entry: start-of-frame flag travels with its pixel
   typedef struct packed {
      logic             sof;
      logic [PIX_W-1:0] data;
   } pix_t;

   // Colour-bar palette, left to right
   localparam logic [PIX_W-1:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [PIX_W-1:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [PIX_W-1:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [PIX_W-1:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [PIX_W-1:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [PIX_W-1:0] BAR_RED     = 24'hFF0000;
   localparam logic [PIX_W-1:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [PIX_W-1:0] BAR_BLACK   = 24'h000000;

   function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
      logic [PIX_W-1:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cl_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// Ports: sys_clk/sys_rst (sync, active-high, clears pointers),
//        wr_en/wr_data (write, ignored while full),
//        rd_en (pop, ignored while empty), head (current front entry),
//        full/empty (registered flags).
module cl_sync_fifo_fwft #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned AW    = 11
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 2**AW;
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_wr;
   logic             do_rd;

   // Flags are registered, so a pop while full does not admit a write that cycle
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;
   assign head  = mem[rd_ptr];

   // Occupancy update
   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   // Pointers and flags
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         empty <= (count_nxt == '0);
      end
   end

   // Storage, no reset needed
   always_ff @(posedge sys_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/cl_pixel_to_vga.sv
// Camera Link pixel stream to raster (RGB/DE/HS/VS) bridge, single pixel clock.
// Ports: sys_clk, sys_rst (sync active-high); s_data/s_sof/s_valid/s_ready
//        (input stream); RGB_DATA, R_DATA/G_DATA/B_DATA, VGA_DE, VGA_HS,
//        VGA_VS (raster out, 1 cycle after the counters); locked (showing
//        aligned input video); underflow_cnt (saturating starved-pixel count).
// Optional: define CL_COLOR_BAR_FALLBACK_EN to show 8 colour bars instead of
//           black on active pixels while not locked.
module cl_pixel_to_vga
   import cl_video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter logic        SYNC_POL = 1'b1,
   parameter int unsigned FIFO_AW  = DEF_FIFO_AW
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_sof,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [PIX_W-1:0] RGB_DATA,
   output logic [7:0]       R_DATA,
   output logic [7:0]       G_DATA,
   output logic [7:0]       B_DATA,
   output logic             VGA_DE,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             locked,
   output logic [15:0]      underflow_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = $clog2(H_TOTAL);
   localparam int unsigned VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   logic             active_c;
   logic             hs_raw;
   logic             vs_raw;
   logic             first_px;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             pop;
   logic             under;
   logic [PIX_W-1:0] pix_nxt;
   logic [PIX_W-1:0] fill_pix;
   pix_t             wr_pix;
   pix_t             head;
   logic             fifo_full;
   logic             fifo_empty;

   // Raster position counters
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // Raw timing decode, registered below
   assign active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_raw   = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_raw   = (v_cnt >= VS_START) && (v_cnt < VS_END);
   assign first_px = (h_cnt == '0) && (v_cnt == '0);

`ifdef CL_COLOR_BAR_FALLBACK_EN
   // Bar index = h_cnt*8/H_ACTIVE via seven constant compares
   logic [HW+2:0] h_x8;
   logic [2:0]    bar_idx;

   always_comb begin
      h_x8    = {h_cnt, 3'b000};
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (h_x8 >= (HW+3)'(k * H_ACTIVE)) bar_idx = 3'(k);
      end
   end

   assign fill_pix = bar_color(bar_idx);
`else
   assign fill_pix = '0;
`endif

   // Input side: write accepted only against the registered full flag
   assign s_ready = ~fifo_full & ~sys_rst;
   assign wr_pix  = '{sof: s_sof, data: s_data};

   cl_sync_fifo_fwft #(
      .WIDTH ($bits(pix_t)),
      .AW    (FIFO_AW)
   ) u_fifo (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (s_valid & s_ready),
      .wr_data (wr_pix),
      .rd_en   (pop),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Output FSM next-state, pop and pixel select
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      under     = 1'b0;
      pix_nxt   = '0;
      if (active_c) pix_nxt = fill_pix;
      case (state)
         ST_SEEK: begin
            if (!fifo_empty) begin
               if (head.sof) state_nxt = ST_WAIT_FRAME;
               else          pop       = 1'b1;
            end
         end
         ST_WAIT_FRAME: begin
            if (first_px && !fifo_empty) begin
               state_nxt = ST_RUN;
               pop       = 1'b1;
               pix_nxt   = head.data;
            end
         end
         ST_RUN: begin
            if (active_c) begin
               if (fifo_empty) begin
                  under     = 1'b1;
                  state_nxt = ST_SEEK;
               end else if (head.sof && !first_px) begin
                  // Next frame arrived early: park it until the raster catches up
                  state_nxt = ST_WAIT_FRAME;
               end else begin
                  pop     = 1'b1;
                  pix_nxt = head.data;
               end
            end
         end
         default: state_nxt = ST_SEEK;
      endcase
   end

   // FSM state register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= ST_SEEK;
      else         state <= state_nxt;
   end

   // Registered raster outputs and status
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         RGB_DATA      <= '0;
         VGA_DE        <= 1'b0;
         VGA_HS        <= ~SYNC_POL;
         VGA_VS        <= ~SYNC_POL;
         locked        <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         RGB_DATA <= pix_nxt;
         VGA_DE   <= active_c;
         VGA_HS   <= hs_raw ? SYNC_POL : ~SYNC_POL;
         VGA_VS   <= vs_raw ? SYNC_POL : ~SYNC_POL;
         locked   <= (state_nxt == ST_RUN);
         if (under && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      end
   end

   assign R_DATA = RGB_DATA[23:16];
   assign G_DATA = RGB_DATA[15:8];
   assign B_DATA = RGB_DATA[7:0];

endmodule
